mux_arbiter_4: RTL and testbench

MUX_ARBITER_4 -- requirements
Module: mux_arbiter_4

---
 rtl/mux_arbiter_4.sv | 124 ++++++++++++
 tb/tb_mux_arbiter_4.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_4.sv
// Four-source round-robin arbiter driving a 4-to-1 mux selector.
// Each owner may hold the grant for at most MAX_HOLD cycles while others wait.
module mux_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] last, last_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       preempt_nxt;
  logic [3:0] gnt_nxt;
  logic       sel_valid_nxt;
  logic [1:0] pick;
  logic [3:0] others;

  // Rotate requests so the slot after 'last' lands on bit 0, take the lowest
  // set bit, then rotate the index back.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] lst);
    logic [2:0] base;
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    base = {1'b0, lst} + 3'd1;
    dbl  = {r, r} >> base;
    rot  = dbl[3:0];
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    return lst + 2'd1 + off;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 2'd0;
      last      <= 2'd3;
      cnt       <= 8'd0;
      gnt       <= 4'b0000;
      sel_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      sel_valid <= sel_valid_nxt;
      preempt   <= preempt_nxt;
    end
  end

  // While granted, last == owner, so the search visits the owner last and any
  // other pending request wins over it.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last;
    cnt_nxt     = cnt;
    preempt_nxt = 1'b0;
    pick        = rr_pick(req, last);
    others      = req & ~(4'b0001 << owner);
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          last_nxt  = pick;
          cnt_nxt   = 8'd1;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          if (|others) begin
            owner_nxt = pick;
            last_nxt  = pick;
            cnt_nxt   = 8'd1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end
        end else if (cnt == HOLD_MAX) begin
          if (|others) begin
            owner_nxt   = pick;
            last_nxt    = pick;
            cnt_nxt     = 8'd1;
            preempt_nxt = 1'b1;
          end else begin
            cnt_nxt = 8'd1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt       = 4'b0000;
    sel_valid_nxt = 1'b0;
    if (state_nxt == GRANT) begin
      gnt_nxt       = 4'b0001 << owner_nxt;
      sel_valid_nxt = 1'b1;
    end
  end

  // The owner register doubles as the mux select, so it holds while idle.
  assign sel = owner;

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Directed bench for mux_arbiter_4 with a cycle-level reference model.
module tb_mux_arbiter_4;
  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       sel_valid;
  logic       preempt;

  int errors = 0;
  int checks = 0;

  mux_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .sel(sel), .sel_valid(sel_valid), .preempt(preempt)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the bus, for how long, who had it last.
  bit m_busy = 1'b0;
  int m_own  = 0;
  int m_last = 3;
  int m_cnt  = 0;
  bit m_pre  = 1'b0;

  initial forever begin
    int hit;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_own = 0; m_last = 3; m_cnt = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      hit = -1;
      for (int i = 1; i <= 4; i++)
        if (hit < 0 && req[(m_last + i) % 4]) hit = (m_last + i) % 4;
      if (!m_busy) begin
        if (hit >= 0) begin m_busy = 1'b1; m_own = hit; m_last = hit; m_cnt = 1; end
      end else if (!req[m_own]) begin
        if (hit >= 0) begin m_own = hit; m_last = hit; m_cnt = 1; end
        else begin m_busy = 1'b0; m_cnt = 0; end
      end else if (m_cnt == MAXH) begin
        if (hit != m_own) begin m_own = hit; m_last = hit; m_cnt = 1; m_pre = 1'b1; end
        else m_cnt = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(posedge clk);
    #1;
    check("model_gnt", 32'(gnt), m_busy ? 32'(4'b0001 << m_own) : 32'd0);
    check("model_sel_valid", 32'(sel_valid), 32'(m_busy));
    check("model_sel", 32'(sel), 32'(m_own));
    check("model_preempt", 32'(preempt), 32'(m_pre));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_sel_valid", 32'(sel_valid), 32'd0);
    check("rst_preempt", 32'(preempt), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_no_req", 32'(sel_valid), 32'd0);

    // All four requesting: rotate every MAXH cycles with a preempt pulse
    req = 4'b1111;
    tick();
    check("rr_first", 32'(gnt), 32'h1);
    check("rr_first_pre", 32'(preempt), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      repeat (MAXH) tick();
      check("rr_rotate_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      check("rr_rotate_pre", 32'(preempt), 32'd1);
    end
    tick();
    check("rr_pre_one_cycle", 32'(preempt), 32'd0);
    req = 4'b0000;
    tick();
    check("rr_idle", 32'(sel_valid), 32'd0);

    // Lone requester beyond MAXH keeps the grant
    req = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      tick();
      check("solo_gnt", 32'(gnt), 32'h4);
      check("solo_sel", 32'(sel), 32'd2);
      check("solo_pre", 32'(preempt), 32'd0);
    end
    req = 4'b0000;
    tick();
    check("solo_idle_sv", 32'(sel_valid), 32'd0);
    check("solo_idle_sel", 32'(sel), 32'd2);

    // Three-cycle pulse on source C
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("pulse_gnt", 32'(gnt), 32'h4);
    end
    req = 4'b0000;
    tick();
    check("pulse_idle_gnt", 32'(gnt), 32'd0);
    check("pulse_idle_sel", 32'(sel), 32'd2);
    check("pulse_idle_sv", 32'(sel_valid), 32'd0);

    // B releases while A and D pend: handover to D with no bubble
    req = 4'b0010;
    tick();
    check("rel_owner_b", 32'(gnt), 32'h2);
    req = 4'b1001;
    tick();
    check("rel_gnt", 32'(gnt), 32'h8);
    check("rel_sel", 32'(sel), 32'd3);
    check("rel_sv", 32'(sel_valid), 32'd1);

    // D releases on its timeout edge: treated as release
    req = 4'b1000;
    repeat (MAXH - 1) tick();
    check("to_rel_hold", 32'(gnt), 32'h8);
    req = 4'b0011;
    tick();
    check("to_rel_gnt", 32'(gnt), 32'h1);
    check("to_rel_pre", 32'(preempt), 32'd0);

    // Async reset in the 5th cycle of a grant
    req = 4'b0001;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_sv", 32'(sel_valid), 32'd0);
    check("async_sel", 32'(sel), 32'd0);
    req = 4'b1010;
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'h2);
    check("post_rst_sel", 32'(sel), 32'd1);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
